// File: rtl/bsg_dlatch_snapshot_pkg.sv
// Shared types and sizing helpers for the snapshot latch bank.
// Defaults here mirror the top-level parameter defaults.
package bsg_dlatch_snapshot_pkg;

  localparam int unsigned def_width_lp     = 32;
  localparam int unsigned def_els_lp       = 4;
  localparam int unsigned def_bus_width_lp = def_els_lp * def_width_lp;

  typedef enum logic [0:0] {
    e_idle = 1'b0,
    e_full = 1'b1
  } state_e;

  // Flattened channel bus width for a given channel count and channel width.
  function automatic int unsigned bus_width(input int unsigned els, input int unsigned width);
    return els * width;
  endfunction

endpackage

// File: rtl/bsg_dlatch_snapshot_chan.sv
// One channel: a clocked hold register standing in for a transparent latch,
// plus the optional zero-latency bypass used while the engine is idle.
module bsg_dlatch_snapshot_chan
  import bsg_dlatch_snapshot_pkg::*;
#(
  parameter int unsigned width_p       = def_width_lp,
  parameter bit          transparent_p = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               idle_i,
  input  logic               en_i,
  input  logic               accept_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] hold_r;

  // Hold register: cleared by reset, loaded when open in idle or on snapshot accept.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hold_r <= {width_p{1'b0}};
    end else if ((idle_i & en_i) | accept_i) begin
      hold_r <= data_i;
    end else begin
      hold_r <= hold_r;
    end
  end

  // Output mux: bypass only while idle and open, never while a snapshot is frozen.
  always_comb begin
    data_o = hold_r;
    if (transparent_p && idle_i && en_i) begin
      data_o = data_i;
    end else begin
      data_o = hold_r;
    end
  end

endmodule

// File: rtl/bsg_dlatch_snapshot.sv
// Bank of els_p latch channels with an atomic snapshot engine (valid/yumi),
// a wrapping snapshot sequence counter and a sticky missed-request flag.
module bsg_dlatch_snapshot
  import bsg_dlatch_snapshot_pkg::*;
#(
  parameter int unsigned width_p       = def_width_lp,
  parameter int unsigned els_p         = def_els_lp,
  parameter bit          transparent_p = 1'b1,
  parameter int unsigned seq_width_p   = 8
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [bus_width(els_p, width_p)-1:0]   data_i,
  input  logic [els_p-1:0]                       en_i,
  input  logic                                   snap_v_i,
  output logic                                   snap_ready_o,
  output logic [bus_width(els_p, width_p)-1:0]   data_o,
  output logic                                   v_o,
  input  logic                                   yumi_i,
  output logic [seq_width_p-1:0]                 seq_o,
  output logic                                   missed_o
);

  state_e                 state_r;
  state_e                 state_n;
  logic [seq_width_p-1:0] seq_r;
  logic                   missed_r;
  logic                   idle_s;
  logic                   accept_s;

  assign idle_s       = (state_r == e_idle);
  assign accept_s     = idle_s & snap_v_i;
  assign snap_ready_o = idle_s;
  assign v_o          = ~idle_s;
  assign seq_o        = seq_r;
  assign missed_o     = missed_r;

  // Next-state logic; yumi in idle is ignored, requests in full are dropped.
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle: begin
        if (snap_v_i) state_n = e_full;
        else          state_n = e_idle;
      end
      e_full: begin
        if (yumi_i) state_n = e_idle;
        else        state_n = e_full;
      end
      default: state_n = e_idle;
    endcase
  end

  // Engine state, sequence counter and sticky missed flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= e_idle;
      seq_r    <= {seq_width_p{1'b0}};
      missed_r <= 1'b0;
    end else begin
      state_r  <= state_n;
      seq_r    <= accept_s ? (seq_r + seq_width_p'(1)) : seq_r;
      missed_r <= missed_r | ((state_r == e_full) & snap_v_i);
    end
  end

  for (genvar k = 0; k < els_p; k++) begin : chan
    bsg_dlatch_snapshot_chan #(
      .width_p      (width_p),
      .transparent_p(transparent_p)
    ) chan_inst (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .idle_i  (idle_s),
      .en_i    (en_i[k]),
      .accept_i(accept_s),
      .data_i  (data_i[k*width_p +: width_p]),
      .data_o  (data_o[k*width_p +: width_p])
    );
  end

endmodule

// File: tb/tb_bsg_dlatch_snapshot.sv
// Randomized plus directed bench for bsg_dlatch_snapshot: three instances
// (transparent, registered-only, 2-bit sequence) share stimulus and one model.
module tb_bsg_dlatch_snapshot;

  logic         clk;
  logic         reset;
  logic [127:0] data_in;
  logic [3:0]   en;
  logic         snap_v;
  logic         yumi;

  logic         ready_a, v_a, missed_a;
  logic [127:0] data_a;
  logic [7:0]   seq_a;
  logic         ready_b, v_b, missed_b;
  logic [127:0] data_b;
  logic [7:0]   seq_b;
  logic         ready_c, v_c, missed_c;
  logic [127:0] data_c;
  logic [1:0]   seq_c;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: abstract channel contents plus engine status.
  logic [31:0] m_hold [4];
  bit          m_full;
  int          m_seq;
  bit          m_missed;

  bsg_dlatch_snapshot #(.width_p(32), .els_p(4), .transparent_p(1'b1), .seq_width_p(8)) dut_a (
    .clk_i(clk), .reset_i(reset), .data_i(data_in), .en_i(en), .snap_v_i(snap_v),
    .snap_ready_o(ready_a), .data_o(data_a), .v_o(v_a), .yumi_i(yumi), .seq_o(seq_a), .missed_o(missed_a));

  bsg_dlatch_snapshot #(.width_p(32), .els_p(4), .transparent_p(1'b0), .seq_width_p(8)) dut_b (
    .clk_i(clk), .reset_i(reset), .data_i(data_in), .en_i(en), .snap_v_i(snap_v),
    .snap_ready_o(ready_b), .data_o(data_b), .v_o(v_b), .yumi_i(yumi), .seq_o(seq_b), .missed_o(missed_b));

  bsg_dlatch_snapshot #(.width_p(32), .els_p(4), .transparent_p(1'b1), .seq_width_p(2)) dut_c (
    .clk_i(clk), .reset_i(reset), .data_i(data_in), .en_i(en), .snap_v_i(snap_v),
    .snap_ready_o(ready_c), .data_o(data_c), .v_o(v_c), .yumi_i(yumi), .seq_o(seq_c), .missed_o(missed_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_data(input bit transp);
    logic [127:0] r;
    for (int k = 0; k < 4; k++)
      r[k*32 +: 32] = (transp && !m_full && en[k]) ? data_in[k*32 +: 32] : m_hold[k];
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) m_hold[k] = 32'h0;
    m_full = 1'b0; m_seq = 0; m_missed = 1'b0;
  endtask

  task automatic model_update();
    if (reset) begin
      model_clear();
    end else if (!m_full) begin
      if (snap_v) begin
        for (int k = 0; k < 4; k++) m_hold[k] = data_in[k*32 +: 32];
        m_seq++;
        m_full = 1'b1;
      end else begin
        for (int k = 0; k < 4; k++) if (en[k]) m_hold[k] = data_in[k*32 +: 32];
      end
    end else begin
      if (snap_v) m_missed = 1'b1;
      if (yumi)   m_full = 1'b0;
    end
  endtask

  // Compare every observable output against the model (at the falling edge).
  task automatic sample();
    @(negedge clk);
    check_val("yumi_legal", {127'b0, yumi & ~m_full}, 128'b0);
    check_val("ready",    {127'b0, ready_a},  {127'b0, ~m_full});
    check_val("v",        {127'b0, v_a},      {127'b0, m_full});
    check_val("v_tp0",    {127'b0, v_b},      {127'b0, m_full});
    check_val("missed",   {127'b0, missed_a}, {127'b0, m_missed});
    check_val("seq8",     {120'b0, seq_a},    128'(m_seq % 256));
    check_val("seq2",     {126'b0, seq_c},    128'(m_seq % 4));
    check_val("data_tp1", data_a, exp_data(1'b1));
    check_val("data_tp0", data_b, exp_data(1'b0));
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  logic [1:0] seq2_exp [5];

  initial begin
    seq2_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    reset = 1'b1; data_in = 128'h0; en = 4'h0; snap_v = 1'b0; yumi = 1'b0;
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Transparent open channel, then hold after close.
    en = 4'b0001; data_in = {96'h0, 32'hDEADBEEF};
    sample();
    check_val("ch0_same_cycle", {96'b0, data_a[31:0]}, {96'b0, 32'hDEADBEEF});
    check_val("ch0_tp0_no_bypass", {96'b0, data_b[31:0]}, 128'h0);
    advance();
    en = 4'b0000; data_in = {32'h1, 32'h2, 32'h3, 32'h4};
    sample();
    check_val("ch0_held", data_a, {96'h0, 32'hDEADBEEF});
    advance();

    // Registered channel 2 updates one cycle after its enable.
    en = 4'b0100; data_in = {32'h0, 32'h12345678, 64'h0};
    tick();
    en = 4'b0000;
    sample();
    check_val("ch2_tp0_late", {96'b0, data_b[95:64]}, {96'b0, 32'h12345678});
    advance();

    // Snapshot capture ignores en_i.
    data_in = {32'hA, 32'hB, 32'hC, 32'hD}; snap_v = 1'b1;
    tick();
    snap_v = 1'b0;
    sample();
    check_val("snap_data", data_a, {32'hA, 32'hB, 32'hC, 32'hD});
    check_val("snap_seq", {120'b0, seq_a}, 128'd1);
    advance();
    for (int i = 0; i < 5; i++) begin
      data_in = {$urandom, $urandom, $urandom, $urandom}; en = 4'($urandom);
      tick();
    end
    check_val("snap_frozen", data_b, {32'hA, 32'hB, 32'hC, 32'hD});

    // Requests while full are missed, including alongside yumi.
    snap_v = 1'b1; tick(); tick();
    yumi = 1'b1; tick();
    snap_v = 1'b0; yumi = 1'b0;
    sample();
    check_val("missed_sticky", {127'b0, missed_a}, 128'd1);
    check_val("seq_still_1", {120'b0, seq_a}, 128'd1);
    advance();
    snap_v = 1'b1; tick();
    snap_v = 1'b0;
    sample();
    check_val("seq_2", {120'b0, seq_a}, 128'd2);
    yumi = 1'b1; advance(); yumi = 1'b0;

    // Two-bit sequence wraps.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      snap_v = 1'b1; tick();
      snap_v = 1'b0; yumi = 1'b1;
      sample();
      check_val("seq2_wrap", {126'b0, seq_c}, {126'b0, seq2_exp[i]});
      advance();
      yumi = 1'b0;
    end

    // Reset while full discards the pending snapshot.
    data_in = {4{32'hCAFEF00D}}; en = 4'b0000;
    snap_v = 1'b1; tick(); snap_v = 1'b1; reset = 1'b1; tick();
    snap_v = 1'b0; reset = 1'b0;
    sample();
    check_val("rst_full_v", {127'b0, v_a}, 128'd0);
    check_val("rst_full_data", data_a, 128'h0);
    check_val("rst_full_ready", {127'b0, ready_a}, 128'd1);
    advance();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      data_in = {$urandom, $urandom, $urandom, $urandom};
      en      = 4'($urandom);
      snap_v  = ($urandom_range(0, 9) < 3);
      yumi    = m_full ? $urandom_range(0, 1) : 1'b0;
      reset   = ($urandom_range(0, 49) == 0);
      tick();
    end
    reset = 1'b0; snap_v = 1'b0; yumi = 1'b0;
    sample();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
